// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: combinational evaluation of the decoded ALU control code,
// results and flags buffered in a 2-entry FIFO toward writeback/branch logic.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int PW = WIDTH + 3;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLT = 4'b0101;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_NOR = 4'b1000;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
    logic        [WIDTH-1:0] alu_res;
    logic                    alu_ovf, alu_ill, alu_zero;

    assign a_s    = op_a;
    assign b_s    = op_b;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            CTRL_ADD: begin
                alu_res = sum_s;
                alu_ovf = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            CTRL_SUB: begin
                alu_res = diff_s;
                alu_ovf = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1]);
            end
            CTRL_AND: alu_res = op_a & op_b;
            CTRL_OR:  alu_res = op_a | op_b;
            // Direct signed compare, so it stays correct when a-b would overflow.
            CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            CTRL_NOR: alu_res = ~(op_a | op_b);
            default:  alu_ill = 1'b1;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    logic [PW-1:0] slot_q [2];
    logic [PW-1:0] slot_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            slot_d[wr_ptr_q] = {alu_ill, alu_ovf, alu_zero, alu_res};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign {illegal, overflow, zero, result} = slot_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: inputs driven and outputs sampled on the
// falling edge, so each check sees state settled after the preceding rising edge.
module tb_alu_exec_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;
    logic          illegal;

    int total = 0;
    int bad   = 0;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ordy);
        in_valid  = v;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic [W-1:0] r, input logic z,
                            input logic o, input logic il);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".result"}, result, r);
        chk({tag, ".zero"}, zero, z);
        chk({tag, ".ovf"}, overflow, o);
        chk({tag, ".ill"}, illegal, il);
    endtask

    initial begin
        int k;
        int j;
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, '0, '0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.result", result, 32'h0);
        chk("rst.flags", {zero, overflow, illegal}, 3'b000);
        rst_n = 1'b1;

        // 1: ADD overflow into sign bit
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        tick();
        chk_head("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'b0010, '0, '0, 1'b1);
        tick();
        chk("add_ovf.drain", out_valid, 1'b0);

        // 2: SUB to zero, signed SLT across the overflow boundary
        drive(1'b1, 4'b0110, 32'd5, 32'd5, 1'b1);
        tick();
        chk_head("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        tick();
        chk_head("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk_head("slt_pos", 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, '0, '0, 1'b1);
        tick();
        chk("slt.drain", out_valid, 1'b0);

        // 3: backpressure fills FIFO; NOR held until space frees
        drive(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        chk("bp.ready0", in_ready, 1'b1);
        tick();
        drive(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        chk("bp.ready1", in_ready, 1'b1);
        tick();
        chk("bp.full", in_ready, 1'b0);
        drive(1'b1, 4'b1000, 32'h0, 32'h0, 1'b0);
        tick();
        chk("bp.still_full", in_ready, 1'b0);
        chk_head("bp.hold_and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp.ready_after_pop", in_ready, 1'b1);
        chk_head("bp.or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        tick();
        chk_head("bp.nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("bp.drain", out_valid, 1'b0);

        // 4a: full-rate stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'b0010, i, 32'd100, 1'b1);
            chk($sformatf("stream.ready%0d", i), in_ready, 1'b1);
            tick();
            chk($sformatf("stream.valid%0d", i), out_valid, 1'b1);
            chk($sformatf("stream.res%0d", i), result, 100 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream.drain", out_valid, 1'b0);

        // 4b: out_ready toggling each cycle, results still in order
        k = 0;
        j = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            if (out_valid && out_ready) begin
                chk($sformatf("toggle.res%0d", k), result, 200 + k);
                k++;
            end
            if (j < 8) begin
                in_valid = 1'b1;
                alu_ctrl = 4'b0010;
                op_a     = j;
                op_b     = 32'd200;
                if (in_ready) j++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            out_ready = ~out_ready;
        end
        chk("toggle.count", k, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("toggle.drain", out_valid, 1'b0);

        // 5: undefined code, then legal ADD clears illegal
        drive(1'b1, 4'b0011, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
        tick();
        chk_head("illegal", 32'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'b0010, 32'd2, 32'd3, 1'b1);
        tick();
        chk_head("after_ill", 32'd5, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();

        // 6: async reset with full FIFO
        drive(1'b1, 4'b0010, 32'd10, 32'd1, 1'b0);
        tick();
        tick();
        chk("arst.full", in_ready, 1'b0);
        chk("arst.valid_before", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid_now", out_valid, 1'b0);
        chk("arst.result_now", result, 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("arst.ready", in_ready, 1'b1);
        chk("arst.empty", out_valid, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("arst.no_stale", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
